// File: rtl/icache_multilane.sv
// Direct-mapped, read-only instruction cache serving NUM_LANES fetch addresses per request.
// Hits return in one cycle; misses refill one line at a time through a valid/ready memory port.
module icache_multilane #(
  parameter int NUM_LANES  = 4,
  parameter int PC_W       = 15,
  parameter int INSTR_W    = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  localparam int OFF_W  = $clog2(LINE_WORDS),
  localparam int IDX_W  = $clog2(NUM_LINES),
  localparam int TAG_W  = PC_W - IDX_W - OFF_W,
  localparam int LINE_W = PC_W - OFF_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [NUM_LANES*PC_W-1:0]    pc_array_flat,
  input  logic                         flush,
  output logic                         resp_valid,
  output logic [NUM_LANES*INSTR_W-1:0] instructions_flat,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [LINE_W-1:0]            mem_req_addr,
  input  logic                         mem_resp_valid,
  input  logic [INSTR_W-1:0]           mem_resp_data
);

  typedef enum logic [1:0] {IDLE, REQ, FILL, RETRY} state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [INSTR_W-1:0]   data_arr [NUM_LINES*LINE_WORDS];

  logic [PC_W-1:0]      pc_in    [NUM_LANES];
  logic [PC_W-1:0]      pc_q     [NUM_LANES];
  logic [INSTR_W-1:0]   slot_q   [NUM_LANES];
  logic [INSTR_W-1:0]   hit_word [NUM_LANES];
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] done_q;

  logic [OFF_W-1:0]     beat_q;
  logic [LINE_W-1:0]    fill_line_q;
  logic [IDX_W-1:0]     fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 last_beat;
  logic                 flush_pend_q;
  logic                 miss_resp_q;
  logic [LINE_W-1:0]    victim_line;
  logic                 victim_found;
  logic                 accept;
  logic                 retry_all_done;

  // In IDLE the live request is looked up; otherwise the captured PCs are re-compared.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [PC_W-1:0]  look;
    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;

    assign pc_in[k]     = pc_array_flat[PC_W*(NUM_LANES-k)-1 -: PC_W];
    assign look         = (state_q == IDLE) ? pc_in[k] : pc_q[k];
    assign look_idx     = look[OFF_W+IDX_W-1:OFF_W];
    assign look_tag     = look[PC_W-1:OFF_W+IDX_W];
    assign hit[k]       = valid_q[look_idx] && (tag_arr[look_idx] == look_tag);
    assign hit_word[k]  = data_arr[look[OFF_W+IDX_W-1:0]];
    assign instructions_flat[INSTR_W*(NUM_LANES-k)-1 -: INSTR_W] = slot_q[k];
  end

  assign fill_idx       = fill_line_q[IDX_W-1:0];
  assign fill_tag       = fill_line_q[LINE_W-1:IDX_W];
  assign last_beat      = (beat_q == OFF_W'(LINE_WORDS - 1));
  assign accept         = req_valid && req_ready;
  assign retry_all_done = &(done_q | hit);

  // The victim is the lowest-numbered lane still waiting for its word.
  always_comb begin
    victim_line  = pc_q[0][PC_W-1:OFF_W];
    victim_found = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!victim_found && !done_q[k]) begin
        victim_line  = pc_q[k][PC_W-1:OFF_W];
        victim_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !(&hit)) state_d = REQ;
      REQ:     if (mem_req_ready) state_d = FILL;
      FILL:    if (mem_resp_valid && last_beat) state_d = RETRY;
      RETRY:   state_d = retry_all_done ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
  end

  // req_ready stays low on the response cycle following a miss so the pulse is not overlapped.
  always_comb begin
    req_ready     = (state_q == IDLE) && !miss_resp_q;
    mem_req_valid = (state_q == REQ);
    mem_req_addr  = victim_line;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      done_q       <= '0;
      resp_valid   <= 1'b0;
      miss_resp_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      beat_q       <= '0;
      fill_line_q  <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        pc_q[k]   <= '0;
        slot_q[k] <= '0;
      end
    end else begin
      resp_valid  <= 1'b0;
      miss_resp_q <= 1'b0;
      if (flush && state_q != IDLE) flush_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            for (int k = 0; k < NUM_LANES; k++) begin
              pc_q[k] <= pc_in[k];
              if (hit[k]) slot_q[k] <= hit_word[k];
            end
            if (&hit) begin
              resp_valid <= 1'b1;
              done_q     <= '0;
            end else begin
              done_q <= hit;
            end
          end
          // The lookup above already used the pre-flush valid bits.
          if (flush) valid_q <= '0;
        end
        REQ: begin
          if (mem_req_ready) begin
            fill_line_q <= victim_line;
            beat_q      <= '0;
          end
        end
        FILL: begin
          if (mem_resp_valid) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) valid_q[fill_idx] <= 1'b1;
          end
        end
        RETRY: begin
          for (int k = 0; k < NUM_LANES; k++) begin
            if (!done_q[k] && hit[k]) slot_q[k] <= hit_word[k];
          end
          if (retry_all_done) begin
            resp_valid   <= 1'b1;
            miss_resp_q  <= 1'b1;
            done_q       <= '0;
            flush_pend_q <= 1'b0;
            if (flush_pend_q || flush) valid_q <= '0;
          end else begin
            done_q <= done_q | hit;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage need no reset: the valid bits guard every read.
  always_ff @(posedge clk) begin
    if (!rst && state_q == FILL && mem_resp_valid) begin
      data_arr[{fill_idx, beat_q}] <= mem_resp_data;
      if (last_beat) tag_arr[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_multilane.sv
// Directed bench for icache_multilane: a line-refill memory model serves words equal to address ^ 0xA5A5.
module tb_icache_multilane;

  localparam int NUM_LANES  = 4;
  localparam int PC_W       = 15;
  localparam int INSTR_W    = 16;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 64;
  localparam int LINE_W     = 13;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         req_valid;
  logic                         req_ready;
  logic [NUM_LANES*PC_W-1:0]    pc_array_flat;
  logic                         flush;
  logic                         resp_valid;
  logic [NUM_LANES*INSTR_W-1:0] instructions_flat;
  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic [LINE_W-1:0]            mem_req_addr;
  logic                         mem_resp_valid;
  logic [INSTR_W-1:0]           mem_resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  int req_cnt = 0;
  logic [LINE_W-1:0] req_log [16];

  int ready_delay   = 0;
  int beat_gap      = 0;
  int beat_limit    = LINE_WORDS;
  int flush_beat    = -1;
  int inject_n      = 0;
  int beats_sent    = 0;
  int addr_unstable = 0;

  icache_multilane #(
    .NUM_LANES  (NUM_LANES),
    .PC_W       (PC_W),
    .INSTR_W    (INSTR_W),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .pc_array_flat     (pc_array_flat),
    .flush             (flush),
    .resp_valid        (resp_valid),
    .instructions_flat (instructions_flat),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      if (req_cnt < 16) req_log[req_cnt] = mem_req_addr;
      req_cnt++;
    end
  end

  // Backing memory: optional accept delay, gaps between beats, truncated refills and stray beats.
  initial begin
    logic [LINE_W-1:0] line;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    flush          = 1'b0;
    forever begin
      @(negedge clk);
      if (inject_n > 0) begin
        for (int i = 0; i < inject_n; i++) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = 16'hDEAD;
          @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        inject_n = 0;
      end else if (mem_req_valid === 1'b1 && !rst) begin
        line = mem_req_addr;
        for (int i = 0; i < ready_delay; i++) begin
          @(negedge clk);
          if (mem_req_valid !== 1'b1 || mem_req_addr !== line) addr_unstable++;
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < beat_limit; b++) begin
          if (b > 0) for (int g = 0; g < beat_gap; g++) @(negedge clk);
          mem_resp_valid = 1'b1;
          mem_resp_data  = {1'b0, line, 2'(b)} ^ 16'hA5A5;
          flush          = (b == flush_beat);
          beats_sent++;
          @(negedge clk);
          mem_resp_valid = 1'b0;
          flush          = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", name, obs, exp);
    end
  endtask

  // Waits for req_ready, presents one request, then counts cycles until resp_valid (1 = next cycle).
  task automatic applyStimulus(input logic [PC_W-1:0] p0, input logic [PC_W-1:0] p1,
                               input logic [PC_W-1:0] p2, input logic [PC_W-1:0] p3,
                               input string name, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    req_valid     = 1'b1;
    pc_array_flat = {p0, p1, p2, p3};
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_resp_seen"}, 64'(resp_valid), 64'd1);
  endtask

  initial begin
    int lat;
    int cnt0;
    int guard;
    req_valid     = 1'b0;
    pc_array_flat = '0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("rst_instructions", instructions_flat, 64'd0);
    checkOutput("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_req_ready", 64'(req_ready), 64'd1);

    $display("[TB] cold miss on line 0");
    applyStimulus(15'h0000, 15'h0001, 15'h0002, 15'h0003, "t1", lat);
    checkOutput("t1_data", instructions_flat, 64'hA5A5_A5A4_A5A7_A5A6);
    checkOutput("t1_req_ready_low", 64'(req_ready), 64'd0);
    checkOutput("t1_req_count", 64'(req_cnt), 64'd1);
    checkOutput("t1_req_addr", 64'(req_log[0]), 64'h000);
    @(negedge clk);
    checkOutput("t1_pulse", 64'(resp_valid), 64'd0);
    checkOutput("t1_hold", instructions_flat, 64'hA5A5_A5A4_A5A7_A5A6);

    $display("[TB] repeat request hits");
    applyStimulus(15'h0000, 15'h0001, 15'h0002, 15'h0003, "t2", lat);
    checkOutput("t2_latency", 64'(lat), 64'd1);
    checkOutput("t2_data", instructions_flat, 64'hA5A5_A5A4_A5A7_A5A6);
    checkOutput("t2_req_count", 64'(req_cnt), 64'd1);
    checkOutput("t2_req_ready_hit", 64'(req_ready), 64'd1);

    $display("[TB] index conflict, three tags on index 1");
    applyStimulus(15'h0004, 15'h0104, 15'h0204, 15'h0005, "t3", lat);
    checkOutput("t3_data", instructions_flat, 64'hA5A1_A4A1_A7A1_A5A0);
    checkOutput("t3_req_count", 64'(req_cnt), 64'd4);
    checkOutput("t3_req_addr0", 64'(req_log[1]), 64'h001);
    checkOutput("t3_req_addr1", 64'(req_log[2]), 64'h041);
    checkOutput("t3_req_addr2", 64'(req_log[3]), 64'h081);

    $display("[TB] slow memory: delayed accept, gapped beats");
    ready_delay = 5;
    beat_gap    = 2;
    applyStimulus(15'h0010, 15'h0011, 15'h0012, 15'h0013, "t4", lat);
    ready_delay = 0;
    beat_gap    = 0;
    checkOutput("t4_data", instructions_flat, 64'hA5B5_A5B4_A5B7_A5B6);
    checkOutput("t4_addr_stable", 64'(addr_unstable), 64'd0);
    checkOutput("t4_req_count", 64'(req_cnt), 64'd5);
    checkOutput("t4_req_addr", 64'(req_log[4]), 64'h004);

    $display("[TB] flush during fill");
    flush_beat = 1;
    applyStimulus(15'h0020, 15'h0021, 15'h0022, 15'h0023, "t5", lat);
    flush_beat = -1;
    checkOutput("t5_data", instructions_flat, 64'hA585_A584_A587_A586);
    checkOutput("t5_req_count", 64'(req_cnt), 64'd6);
    applyStimulus(15'h0000, 15'h0001, 15'h0002, 15'h0003, "t5b", lat);
    checkOutput("t5b_missed", 64'(lat > 1), 64'd1);
    checkOutput("t5b_req_count", 64'(req_cnt), 64'd7);
    checkOutput("t5b_req_addr", 64'(req_log[6]), 64'h000);
    checkOutput("t5b_data", instructions_flat, 64'hA5A5_A5A4_A5A7_A5A6);
    applyStimulus(15'h0000, 15'h0001, 15'h0002, 15'h0003, "t5c", lat);
    checkOutput("t5c_latency", 64'(lat), 64'd1);

    $display("[TB] reset during fill with two beats outstanding");
    beat_limit = 2;
    @(negedge clk);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    req_valid     = 1'b1;
    pc_array_flat = {15'h0030, 15'h0031, 15'h0032, 15'h0033};
    cnt0 = beats_sent;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (beats_sent < cnt0 + 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    checkOutput("t6_partial_beats", 64'(beats_sent - cnt0), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    beat_limit = LINE_WORDS;
    inject_n   = 2;
    repeat (4) @(negedge clk);
    checkOutput("t6_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("t6_mem_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("t6_instructions", instructions_flat, 64'd0);
    checkOutput("t6_req_ready", 64'(req_ready), 64'd1);
    cnt0 = req_cnt;
    applyStimulus(15'h0000, 15'h0001, 15'h0002, 15'h0003, "t6b", lat);
    checkOutput("t6b_missed", 64'(lat > 1), 64'd1);
    checkOutput("t6b_req_count", 64'(req_cnt - cnt0), 64'd1);
    checkOutput("t6b_data", instructions_flat, 64'hA5A5_A5A4_A5A7_A5A6);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_multilane.md
Name: icache_multilane

Overview:
- Parametrised, direct-mapped, read-only instruction cache serving NUM_LANES independent fetch addresses per request.
- Next generation of the fetch-stage instruction store: the flat 32K-word array is replaced by a tagged cache backed by a line-refill memory port.
- Sits between the fetch/PC-generation stage and the backing instruction memory.
- Hits return in one cycle; misses are refilled one line at a time through a valid/ready request port and a beat-per-word response port.

Parameters:
- NUM_LANES, 4: fetch lanes per request.
- PC_W, 15: word-address width per lane.
- INSTR_W, 16: instruction word width.
- LINE_WORDS, 4: words per cache line; power of two, at least 2.
- NUM_LINES, 64: lines in the cache; power of two.
- Derived:
  - OFF_W = $clog2(LINE_WORDS)
  - IDX_W = $clog2(NUM_LINES)
  - TAG_W = PC_W - IDX_W - OFF_W, which must be at least 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  cache can accept a request; high only in IDLE.
- pc_array_flat  in  NUM_LANES*PC_W  lane word addresses; lane 0 in the most-significant slice, lane k at bits [PC_W*(NUM_LANES-k)-1 : PC_W*(NUM_LANES-1-k)].
- flush  in  1  invalidate all lines.
- resp_valid  out  1  one-cycle pulse; instructions_flat is valid.
- instructions_flat  out  NUM_LANES*INSTR_W  fetched words; same lane ordering as the PCs.
- mem_req_valid  out  1  line refill request.
- mem_req_ready  in  1  backing memory accepts the request.
- mem_req_addr  out  PC_W-OFF_W  line address (tag and index).
- mem_resp_valid  in  1  one refill word this cycle.
- mem_resp_data  in  INSTR_W  refill word; words arrive in offset order 0 to LINE_WORDS-1.

Behaviour:
- Address split, per PC:
  - offset = pc[OFF_W-1:0]
  - index = pc[OFF_W+IDX_W-1:OFF_W]
  - tag = upper TAG_W bits
- Storage:
  - per-line valid bit, cleared by reset and flush;
  - tag array;
  - data array of NUM_LINES*LINE_WORDS words.
- Reset:
  - state = IDLE; all valid bits = 0;
  - resp_valid = 0, mem_req_valid = 0;
  - instructions_flat = 0, mem_req_addr = 0;
  - lane done-mask cleared.
  - Reset mid-refill abandons the refill; later mem_resp_valid beats are ignored outside FILL.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture all PCs and tag-compare every lane against the array that cycle.
  - For each hitting lane, register its word into the output slot and set its done bit.
  - If all lanes hit: resp_valid = 1 next cycle (latency 1), stay IDLE.
  - Otherwise go to REQ.
- REQ:
  - Victim lane = lowest-numbered lane not done.
  - mem_req_valid = 1; mem_req_addr = that lane's line address, held stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready, go to FILL with beat counter = 0.
- FILL:
  - Each mem_resp_valid writes data[index][counter] and increments the counter.
  - On the beat where counter = LINE_WORDS-1: write the tag, set valid, go to RETRY.
  - Gaps between beats are permitted.
- RETRY (one cycle):
  - Re-compare all not-done captured lanes.
  - Hits are latched into their slots and marked done.
  - If all lanes are done: resp_valid = 1 next cycle, return to IDLE, clear the done-mask.
  - Otherwise go to REQ.
- Miss latency: 1 + handshake + LINE_WORDS beats + 1 per distinct missing line, plus 1 for the response.
- Index conflicts: lanes sharing an index with different tags are served progressively. Already-done words are held in output registers, so eviction never causes livelock.
- Duplicate lines: several lanes missing the same line trigger exactly one refill.
- flush:
  - In IDLE with no req_valid: clears all valid bits, takes effect next cycle.
  - Together with req_valid in IDLE: the lookup uses pre-flush contents and the flush then applies.
  - In REQ, FILL or RETRY: the flush is latched and applied on return to IDLE, after the in-flight request completes.
- Outputs:
  - req_ready is low in REQ, FILL and RETRY, and on the response cycle of a miss return.
  - instructions_flat holds its last value between pulses.

Test Plan:
- Reset, then request PCs {0x0000,0x0001,0x0002,0x0003} with memory words = address^0xA5A5 -> one refill of line 0x0000 (4 beats); resp_valid with {0xA5A5,0xA5A4,0xA5A7,0xA5A6}; mem_req issued exactly once.
- Repeat the same request -> resp_valid exactly 1 cycle after acceptance; mem_req_valid stays 0.
- Lanes {0x0004,0x0104,0x0204,0x0005} (same index 1, 3 distinct tags) -> 3 refills in lane order; all four words correct; no livelock.
- Memory with 2 idle cycles between beats and mem_req_ready delayed 5 cycles -> mem_req_addr stable until accepted; data correct.
- Assert flush during FILL, then re-request a previously cached line -> current response correct; the following request misses and refills.
- Assert rst during FILL with 2 beats outstanding, then inject those beats -> beats ignored; valid bits 0; the next request of the same line misses.
